// File: rtl/ext_arbiter_pkg.sv
// Shared types and defaults for the two-requester immediate sign-extension arbiter.
package ext_arbiter_pkg;

  localparam int DATASIZE_DEF = 16;
  localparam int EXT6SIZE_DEF = 6;
  localparam int REQ_ID_W     = 1;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/ext_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the result consumer.
interface ext_arbiter_if
  import ext_arbiter_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int EXT6SIZE = EXT6SIZE_DEF
);
  logic                req0_valid;
  logic [EXT6SIZE-1:0] req0_imm;
  logic                req0_ready;
  logic                req1_valid;
  logic [EXT6SIZE-1:0] req1_imm;
  logic                req1_ready;
  logic                out_valid;
  logic                out_ready;
  logic [DATASIZE-1:0] out_data;
  req_id_t             out_id;

  // Requester/consumer side.
  modport master (
    output req0_valid, req0_imm, req1_valid, req1_imm, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_id
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_imm, req1_valid, req1_imm, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/ext_rr_pick.sv
// Two-way round-robin grant: ties go to the requester not granted most recently.
module ext_rr_pick
  import ext_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    valid0_i,
  input  logic    valid1_i,
  input  logic    accept_i,
  output logic    ready0_o,
  output logic    ready1_o,
  output req_id_t gnt_id_o
);

  req_id_t last_q;
  req_id_t last_d;
  logic    grant0;
  logic    grant1;

  // Priority pick with the round-robin pointer breaking ties.
  always_comb begin
    grant0 = valid0_i && (!valid1_i || (last_q == 1'b1));
    grant1 = valid1_i && (!valid0_i || (last_q == 1'b0));
    ready0_o = accept_i && grant0;
    ready1_o = accept_i && grant1;
    gnt_id_o = grant1 ? 1'b1 : 1'b0;
    if (ready0_o) begin
      last_d = 1'b0;
    end else if (ready1_o) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
  end

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ext_arbiter.sv
// Arbitrates two immediate requesters into one registered, sign-extended result stage.
// Optional per-requester transfer counters are enabled by defining EXT_ARB_STATS_EN.
module ext_arbiter
  import ext_arbiter_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int EXT6SIZE = EXT6SIZE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  ext_arbiter_if.slave bus
`ifdef EXT_ARB_STATS_EN
  ,
  output logic [15:0]  stat0_cnt,
  output logic [15:0]  stat1_cnt
`endif
);

  stage_state_e        state_q;
  logic [DATASIZE-1:0] out_data_q;
  req_id_t             out_id_q;
  logic [DATASIZE-1:0] data_d;
  logic [EXT6SIZE-1:0] imm_sel;
  req_id_t             gnt_id;
  logic                accept;
  logic                ready0;
  logic                ready1;
  logic                xfer;

  // Stage can take a new result when empty or when the held one leaves this cycle.
  assign accept = rst_n && ((state_q == ST_EMPTY) || bus.out_ready);
  assign xfer   = ready0 || ready1;

  ext_rr_pick u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid0_i (bus.req0_valid),
    .valid1_i (bus.req1_valid),
    .accept_i (accept),
    .ready0_o (ready0),
    .ready1_o (ready1),
    .gnt_id_o (gnt_id)
  );

  assign imm_sel = (gnt_id == 1'b1) ? bus.req1_imm : bus.req0_imm;
  assign data_d  = {{(DATASIZE-EXT6SIZE){imm_sel[EXT6SIZE-1]}}, imm_sel};

  // Output stage FSM; a reset discards any held result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_id_q   <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (xfer) begin
            state_q    <= ST_FULL;
            out_data_q <= data_d;
            out_id_q   <= gnt_id;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            out_data_q <= data_d;
            out_id_q   <= gnt_id;
          end else if (bus.out_ready) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.out_valid  = (state_q == ST_FULL);
  assign bus.out_data   = out_data_q;
  assign bus.out_id     = out_id_q;

`ifdef EXT_ARB_STATS_EN
  logic [15:0] stat0_q;
  logic [15:0] stat1_q;

  // Saturating transfer counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat0_q <= 16'h0000;
      stat1_q <= 16'h0000;
    end else begin
      if (ready0 && (stat0_q != 16'hFFFF)) begin
        stat0_q <= stat0_q + 16'h0001;
      end
      if (ready1 && (stat1_q != 16'hFFFF)) begin
        stat1_q <= stat1_q + 16'h0001;
      end
    end
  end

  assign stat0_cnt = stat0_q;
  assign stat1_cnt = stat1_q;
`endif

endmodule

// File: tb/tb_ext_arbiter.sv
// Self-checking bench for ext_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_ext_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ext_arbiter_if #(.DATASIZE(16), .EXT6SIZE(6)) bus ();

`ifdef EXT_ARB_STATS_EN
  logic [15:0] stat0_cnt;
  logic [15:0] stat1_cnt;
`endif

  ext_arbiter #(.DATASIZE(16), .EXT6SIZE(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef EXT_ARB_STATS_EN
    ,
    .stat0_cnt (stat0_cnt),
    .stat1_cnt (stat1_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two's-complement value of a 6-bit field, truncated to 16 bits.
  function automatic logic [15:0] sext_ref(input int imm);
    int s;
    s = (imm >= 32) ? (imm - 64) : imm;
    return 16'(s);
  endfunction

  task automatic drive(input logic v0, input logic [5:0] i0, input logic v1,
                       input logic [5:0] i1, input logic ordy);
    bus.req0_valid = v0;
    bus.req0_imm   = i0;
    bus.req1_valid = v1;
    bus.req1_imm   = i1;
    bus.out_ready  = ordy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 6'h15, 1'b1, 6'h2A, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.out_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got v=%b d=%h id=%b want v=0 d=0000 id=0",
               bus.out_valid, bus.out_data, bus.out_id);
    end
    rst_n = 1'b1;
    drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_sign_ext();
    do_reset();
    drive(1'b1, 6'b100000, 1'b0, 6'h00, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL sext_ready got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hFFE0 || bus.out_id !== 1'b0) begin
      errors++;
      $display("FAIL sext_out got v=%b d=%h id=%b want v=1 d=ffe0 id=0",
               bus.out_valid, bus.out_data, bus.out_id);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_d;
    do_reset();
    drive(1'b1, 6'h05, 1'b1, 6'h3F, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        checks++;
        if (bus.req0_ready !== ((k % 2) == 0) || bus.req1_ready !== ((k % 2) == 1)) begin
          errors++;
          $display("FAIL rr_grant k=%0d got %b%b", k, bus.req0_ready, bus.req1_ready);
        end
      end
      if (k > 0) begin
        exp_d = ((k - 1) % 2 == 0) ? 16'h0005 : 16'hFFFF;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d ||
            bus.out_id !== 1'(((k - 1) % 2))) begin
          errors++;
          $display("FAIL rr_data k=%0d got v=%b d=%h id=%b want d=%h",
                   k, bus.out_valid, bus.out_data, bus.out_id, exp_d);
        end
      end
      @(posedge clk);
      #1;
      if (k == 3) drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 6'h2A, 1'b0, 6'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_load got ready0=%b want 1", bus.req0_ready);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 6'h00, 1'b1, 6'h11, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.req1_ready !== 1'b0 || bus.req0_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          bus.out_data !== 16'hFFEA || bus.out_id !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold k=%0d got r=%b%b v=%b d=%h id=%b want r=00 v=1 d=ffea id=0",
                 k, bus.req0_ready, bus.req1_ready, bus.out_valid, bus.out_data, bus.out_id);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_pass got ready1=%b want 1", bus.req1_ready);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0011 || bus.out_id !== 1'b1) begin
      errors++;
      $display("FAIL stall_next got v=%b d=%h id=%b want v=1 d=0011 id=1",
               bus.out_valid, bus.out_data, bus.out_id);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty got v=%b want 0", bus.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 6'h3F, 1'b0, 6'h00, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1'b1, 6'h01, 1'b1, 6'h02, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.out_id !== 1'b0) begin
        errors++;
        $display("FAIL midrst_out k=%0d got v=%b d=%h id=%b want v=0 d=0000 id=0",
                 k, bus.out_valid, bus.out_data, bus.out_id);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    logic [16:0] exp_q[$];
    logic        last_gnt;
    logic        v0, v1, ordy, rs, full, can, g0, g1, e0, e1;
    logic [5:0]  i0, i1;
    do_reset();
    last_gnt = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      v0   = 1'($urandom_range(0, 1));
      v1   = 1'($urandom_range(0, 1));
      i0   = 6'($urandom_range(0, 63));
      i1   = 6'($urandom_range(0, 63));
      ordy = ($urandom_range(0, 3) != 0);
      rs   = ($urandom_range(0, 99) != 0);
      rst_n = rs;
      drive(v0, i0, v1, i1, ordy);
      full = (exp_q.size() != 0);
      can  = rs && (!full || ordy);
      g0   = v0 && (!v1 || last_gnt);
      g1   = v1 && (!v0 || !last_gnt);
      e0   = can && g0;
      e1   = can && g1;
      @(negedge clk);
      checks++;
      if (bus.req0_ready !== e0 || bus.req1_ready !== e1 || bus.out_valid !== full) begin
        errors++;
        $display("FAIL rand_hs c=%0d got r=%b%b v=%b want r=%b%b v=%b",
                 c, bus.req0_ready, bus.req1_ready, bus.out_valid, e0, e1, full);
      end
      if (full) begin
        checks++;
        if ({bus.out_id, bus.out_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL rand_data c=%0d got %h want %h", c, {bus.out_id, bus.out_data}, exp_q[0]);
        end
      end
      @(posedge clk);
      #1;
      if (!rs) begin
        exp_q.delete();
        last_gnt = 1'b1;
      end else begin
        if (full && ordy) void'(exp_q.pop_front());
        if (e0) begin
          exp_q.push_back({1'b0, sext_ref(int'(i0))});
          last_gnt = 1'b0;
        end
        if (e1) begin
          exp_q.push_back({1'b1, sext_ref(int'(i1))});
          last_gnt = 1'b1;
        end
      end
    end
    rst_n = 1'b1;
    drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
  endtask

`ifdef EXT_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    @(negedge clk);
    checks++;
    if (stat0_cnt !== 16'h0000 || stat1_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL stat_reset got %h %h want 0000 0000", stat0_cnt, stat1_cnt);
    end
    @(posedge clk);
    #1;
    drive(1'b1, 6'h01, 1'b0, 6'h00, 1'b1);
    for (int k = 0; k < 70000; k++) begin
      @(posedge clk);
    end
    #1;
    drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
    @(negedge clk);
    checks++;
    if (stat0_cnt !== 16'hFFFF || stat1_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL stat_sat got %h %h want ffff 0000", stat0_cnt, stat1_cnt);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
    test_reset();
    test_sign_ext();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef EXT_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
